mant_addsub_pipe: RTL

- Parametrised, pipelined mantissa add/subtract unit for the floating-point adder datapath.
- Generational successor to the fixed 24-bit combinational subtractor. Adds:
  - width parameter
  - runtime add/sub mode
  - carry-chain split across pipeline stages
  - valid/ready handshake with backpressure
  - sideband tag passthrough
- Sits between the exponent-align stage and the normalise/round stage.

---
 rtl/mant_addsub_pipe.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mant_addsub_pipe.sv
// Pipelined mantissa add/subtract; the carry chain is cut into STAGES equal chunks, one per register stage.
// Optional MANT_ADDSUB_ABS_RESULT_EN adds an output stage that turns borrowing subtractions into |A-B|.
module mant_addsub_pipe #(
   parameter int WIDTH  = 24,
   parameter int STAGES = 2,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_neg,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int C = WIDTH / STAGES;
   localparam int L = STAGES - 1;

   generate
      if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
         $error("mant_addsub_pipe: STAGES must be in 1..WIDTH and divide WIDTH");
      end
   endgenerate

   // Handshake: a beat transfers on any cycle where valid and ready are both high. The
   // whole pipe shifts together when the output register is empty or being drained.
   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Inputs seen by each stage: the ports for stage 0, the previous stage register otherwise.
   logic             src_v [STAGES];
   logic [WIDTH-1:0] src_a [STAGES];
   logic [WIDTH-1:0] src_b [STAGES];
   logic [WIDTH-1:0] src_r [STAGES];
   logic             src_c [STAGES];
   logic             src_s [STAGES];
   logic [TAG_W-1:0] src_t [STAGES];

   logic             v_q [STAGES];
   logic             v_d [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] a_d [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] b_d [STAGES];
   logic [WIDTH-1:0] r_q [STAGES];
   logic [WIDTH-1:0] r_d [STAGES];
   logic             c_q [STAGES];
   logic             c_d [STAGES];
   logic             s_q [STAGES];
   logic             s_d [STAGES];
   logic [TAG_W-1:0] t_q [STAGES];
   logic [TAG_W-1:0] t_d [STAGES];

   logic fc_q, fc_d;
   logic fz_q, fz_d;

   always_comb begin
      src_v[0] = in_valid;
      src_a[0] = in_a;
      src_b[0] = in_b ^ {WIDTH{in_sub}};
      src_r[0] = '0;
      src_c[0] = in_sub;
      src_s[0] = in_sub;
      src_t[0] = in_tag;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = v_q[k-1];
         src_a[k] = a_q[k-1];
         src_b[k] = b_q[k-1];
         src_r[k] = r_q[k-1];
         src_c[k] = c_q[k-1];
         src_s[k] = s_q[k-1];
         src_t[k] = t_q[k-1];
      end
   end

   always_comb begin : stage_math
      logic [C:0] sum;
      sum = '0;
      for (int k = 0; k < STAGES; k++) begin
         sum = {1'b0, src_a[k][k*C +: C]} + {1'b0, src_b[k][k*C +: C]} + {{C{1'b0}}, src_c[k]};
         v_d[k] = src_v[k];
         a_d[k] = src_a[k];
         b_d[k] = src_b[k];
         r_d[k] = src_r[k];
         r_d[k][k*C +: C] = sum[C-1:0];
         c_d[k] = sum[C];
         s_d[k] = src_s[k];
         t_d[k] = src_t[k];
      end
      // Subtraction reports a borrow, which is the inverted carry out of A + ~B + 1.
      fc_d = c_d[L] ^ s_d[L];
      fz_d = (r_d[L] == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            r_q[k] <= '0;
            c_q[k] <= 1'b0;
            s_q[k] <= 1'b0;
            t_q[k] <= '0;
         end
         fc_q <= 1'b0;
         fz_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_d[k];
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            r_q[k] <= r_d[k];
            c_q[k] <= c_d[k];
            s_q[k] <= s_d[k];
            t_q[k] <= t_d[k];
         end
         fc_q <= fc_d;
         fz_q <= fz_d;
      end
   end

`ifdef MANT_ADDSUB_ABS_RESULT_EN
   logic             xv_q, xv_d;
   logic [WIDTH-1:0] xr_q, xr_d;
   logic             xc_q, xc_d;
   logic             xn_q, xn_d;
   logic             xz_q, xz_d;
   logic [TAG_W-1:0] xt_q, xt_d;

   // A borrowing subtraction holds A-B+2^WIDTH; negating it yields B-A.
   always_comb begin
      xv_d = v_q[L];
      xn_d = s_q[L] & fc_q;
      xr_d = xn_d ? (~r_q[L] + WIDTH'(1)) : r_q[L];
      xc_d = fc_q;
      xz_d = (xr_d == '0);
      xt_d = t_q[L];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xv_q <= 1'b0;
         xr_q <= '0;
         xc_q <= 1'b0;
         xn_q <= 1'b0;
         xz_q <= 1'b0;
         xt_q <= '0;
      end else if (adv) begin
         xv_q <= xv_d;
         xr_q <= xr_d;
         xc_q <= xc_d;
         xn_q <= xn_d;
         xz_q <= xz_d;
         xt_q <= xt_d;
      end
   end

   assign out_valid  = xv_q;
   assign out_result = xr_q;
   assign out_carry  = xc_q;
   assign out_neg    = xn_q;
   assign out_zero   = xz_q;
   assign out_tag    = xt_q;
`else
   assign out_valid  = v_q[L];
   assign out_result = r_q[L];
   assign out_carry  = fc_q;
   assign out_neg    = 1'b0;
   assign out_zero   = fz_q;
   assign out_tag    = t_q[L];
`endif

endmodule
